alu_datamem_stage: RTL and testbench

ALU_DATAMEM_STAGE -- requirements
Module: alu_datamem_stage

---
 rtl/alu_datamem_stage_pkg.sv | 32 +++
 rtl/alu_core.sv | 34 +++
 rtl/alu_datamem_stage.sv | 77 +++++++
 tb/tb_alu_datamem_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_datamem_stage_pkg.sv
// Shared encodings for the ALU / data-memory stage: ALU control codes, main-controller
// ALU operation classes and the instruction opcodes the ALU decoder understands.
package alu_datamem_stage_pkg;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluInv = 3'b010,
    AluShl = 3'b011,
    AluShr = 3'b100,
    AluAnd = 3'b101,
    AluOr  = 3'b110,
    AluSlt = 3'b111
  } alu_cnt_e;

  typedef enum logic [1:0] {
    AluOpRtype = 2'b00,
    AluOpBranch = 2'b01,
    AluOpMem   = 2'b10,
    AluOpRsvd  = 2'b11
  } alu_op_e;

  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0011;
  localparam logic [3:0] OpInv = 4'b0100;
  localparam logic [3:0] OpShl = 4'b0101;
  localparam logic [3:0] OpShr = 4'b0110;
  localparam logic [3:0] OpAnd = 4'b0111;
  localparam logic [3:0] OpOr  = 4'b1000;
  localparam logic [3:0] OpSlt = 4'b1001;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 16-bit ALU with a zero flag; add/sub wrap, shifts saturate to 0.
module alu_core
  import alu_datamem_stage_pkg::*;
(
  input  alu_cnt_e    alu_cnt_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] result_o,
  output logic        zero_o
);

  logic shamt_big;

  // The full 16-bit b is the shift amount, so anything past 15 clears the result.
  assign shamt_big = (b_i > 16'd15);

  always_comb begin
    result_o = 16'h0000;
    unique case (alu_cnt_i)
      AluAdd: result_o = a_i + b_i;
      AluSub: result_o = a_i - b_i;
      AluInv: result_o = ~a_i;
      AluShl: result_o = shamt_big ? 16'h0000 : (a_i << b_i[3:0]);
      AluShr: result_o = shamt_big ? 16'h0000 : (a_i >> b_i[3:0]);
      AluAnd: result_o = a_i & b_i;
      AluOr:  result_o = a_i | b_i;
      AluSlt: result_o = {15'h0000, (a_i < b_i)};
      default: result_o = 16'h0000;
    endcase
  end

  assign zero_o = (result_o == 16'h0000);

endmodule

// File: rtl/alu_datamem_stage.sv
// Execute + data-memory stage: ALU control decode, ALU, and a word-addressed data memory
// indexed by the ALU result byte address.
module alu_datamem_stage
  import alu_datamem_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  alu_op,
  input  logic [3:0]  opcode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] mem_write_data,
  input  logic        mem_write_en,
  input  logic        mem_read,
  output logic [2:0]  alu_cnt,
  output logic [15:0] alu_result,
  output logic        zero,
  output logic [15:0] mem_read_data
);

  alu_cnt_e        alu_cnt_sel;
  logic [AW-1:0]   mem_idx;
  logic [15:0]     mem_q [DEPTH];
  logic            unused_addr_bits;

  always_comb begin
    alu_cnt_sel = AluAdd;
    unique case (alu_op)
      AluOpRtype: begin
        case (opcode)
          OpAdd:   alu_cnt_sel = AluAdd;
          OpSub:   alu_cnt_sel = AluSub;
          OpInv:   alu_cnt_sel = AluInv;
          OpShl:   alu_cnt_sel = AluShl;
          OpShr:   alu_cnt_sel = AluShr;
          OpAnd:   alu_cnt_sel = AluAnd;
          OpOr:    alu_cnt_sel = AluOr;
          OpSlt:   alu_cnt_sel = AluSlt;
          default: alu_cnt_sel = AluAdd;
        endcase
      end
      AluOpBranch: alu_cnt_sel = AluSub;
      AluOpMem:    alu_cnt_sel = AluAdd;
      default:     alu_cnt_sel = AluAdd;
    endcase
  end

  assign alu_cnt = alu_cnt_sel;

  alu_core u_alu_core (
    .alu_cnt_i (alu_cnt_sel),
    .a_i       (a),
    .b_i       (b),
    .result_o  (alu_result),
    .zero_o    (zero)
  );

  // Byte address: bit 0 aliases odd bytes onto their word, bits above AW wrap.
  assign mem_idx          = alu_result[AW:1];
  assign unused_addr_bits = ^{alu_result[15:AW+1], alu_result[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (mem_write_en) begin
      mem_q[mem_idx] <= mem_write_data;
    end
  end

  assign mem_read_data = mem_read ? mem_q[mem_idx] : 16'h0000;

endmodule

// File: tb/tb_alu_datamem_stage.sv
// Directed self-checking bench for alu_datamem_stage with hand-computed expectations.
module tb_alu_datamem_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [2:0]  alu_cnt;
  logic [15:0] alu_result;
  logic        zero;
  logic [15:0] mem_read_data;

  int checks;
  int errors;

  alu_datamem_stage #(
    .DEPTH (8),
    .AW    (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_op         (alu_op),
    .opcode         (opcode),
    .a              (a),
    .b              (b),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read       (mem_read),
    .alu_cnt        (alu_cnt),
    .alu_result     (alu_result),
    .zero           (zero),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    alu_op = 2'b10; opcode = 4'b0000; a = addr; b = 16'h0000;
    mem_write_data = data; mem_write_en = 1'b1;
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
  endtask

  task automatic set_read(input logic [15:0] addr);
    alu_op = 2'b10; opcode = 4'b0000; a = addr; b = 16'h0000; mem_read = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_op = 2'b00; opcode = 4'b0010; a = 16'h0000; b = 16'h0000;
    mem_write_data = 16'h0000; mem_write_en = 1'b0; mem_read = 1'b1;
    #12;
    checks++;
    if (mem_read_data !== 16'h0000 || zero !== 1'b1 || alu_result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: rd=%h zero=%b res=%h, required rd=0000 zero=1 res=0000",
               mem_read_data, zero, alu_result);
    end
    a = 16'h0005; b = 16'h0003; #1;
    checks++;
    if (alu_result !== 16'h0008 || zero !== 1'b0 || alu_cnt !== 3'b000) begin
      errors++;
      $display("FAIL reset_alu_tracks: res=%h zero=%b cnt=%b, required 0008 0 000",
               alu_result, zero, alu_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    alu_op = 2'b00; opcode = 4'b0010; a = 16'h7FFF; b = 16'h0001; mem_read = 1'b0; #1;
    checks++;
    if (alu_cnt !== 3'b000 || alu_result !== 16'h8000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL add_overflow: cnt=%b res=%h zero=%b, required 000 8000 0",
               alu_cnt, alu_result, zero);
    end
    a = 16'hFFFF; b = 16'h0001; #1;
    checks++;
    if (alu_result !== 16'h0000 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: res=%h zero=%b, required 0000 1", alu_result, zero);
    end
  endtask

  task automatic test_sub();
    alu_op = 2'b01; opcode = 4'b0000; a = 16'h1234; b = 16'h1234; #1;
    checks++;
    if (alu_cnt !== 3'b001 || alu_result !== 16'h0000 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_equal: cnt=%b res=%h zero=%b, required 001 0000 1",
               alu_cnt, alu_result, zero);
    end
    a = 16'h0003; b = 16'h0005; #1;
    checks++;
    if (alu_result !== 16'hFFFE || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: res=%h zero=%b, required fffe 0", alu_result, zero);
    end
  endtask

  task automatic test_decode_ops();
    logic [3:0]  ops  [8] = '{4'b0010, 4'b0011, 4'b0100, 4'b0101,
                              4'b0110, 4'b0111, 4'b1000, 4'b1001};
    logic [2:0]  cnts [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                              3'b100, 3'b101, 3'b110, 3'b111};
    logic [15:0] ress [8] = '{16'h00F4, 16'h00EC, 16'hFF0F, 16'h0F00,
                              16'h000F, 16'h0000, 16'h00F4, 16'h0000};
    alu_op = 2'b00; a = 16'h00F0; b = 16'h0004;
    for (int i = 0; i < 8; i++) begin
      opcode = ops[i]; #1;
      checks++;
      if (alu_cnt !== cnts[i] || alu_result !== ress[i] || zero !== (ress[i] == 16'h0000)) begin
        errors++;
        $display("FAIL decode_op_%b: cnt=%b res=%h zero=%b, required %b %h %b", ops[i],
                 alu_cnt, alu_result, zero, cnts[i], ress[i], (ress[i] == 16'h0000));
      end
    end
    opcode = 4'b1001; b = 16'h0100; #1;
    checks++;
    if (alu_result !== 16'h0001 || zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_true: res=%h zero=%b, required 0001 0", alu_result, zero);
    end
    opcode = 4'b0101; b = 16'd16; #1;
    checks++;
    if (alu_result !== 16'h0000 || zero !== 1'b1) begin
      errors++;
      $display("FAIL shl_by_16: res=%h zero=%b, required 0000 1", alu_result, zero);
    end
    opcode = 4'b0110; b = 16'h0101; #1;
    checks++;
    if (alu_result !== 16'h0000) begin
      errors++;
      $display("FAIL shr_by_257: res=%h, required 0000", alu_result);
    end
    opcode = 4'b0101; b = 16'd15; a = 16'h0003; #1;
    checks++;
    if (alu_result !== 16'h8000) begin
      errors++;
      $display("FAIL shl_by_15: res=%h, required 8000", alu_result);
    end
    opcode = 4'b1111; a = 16'h0003; b = 16'h0004; #1;
    checks++;
    if (alu_cnt !== 3'b000 || alu_result !== 16'h0007) begin
      errors++;
      $display("FAIL undefined_opcode: cnt=%b res=%h, required 000 0007", alu_cnt, alu_result);
    end
    alu_op = 2'b11; opcode = 4'b1001; #1;
    checks++;
    if (alu_cnt !== 3'b000 || alu_result !== 16'h0007) begin
      errors++;
      $display("FAIL aluop_11: cnt=%b res=%h, required 000 0007", alu_cnt, alu_result);
    end
  endtask

  task automatic test_memory();
    @(negedge clk);
    alu_op = 2'b10; a = 16'h0002; b = 16'h0004;
    mem_write_data = 16'hBEEF; mem_write_en = 1'b1; mem_read = 1'b0;
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
    set_read(16'h0006);
    checks++;
    if (mem_read_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL mem_read_addr6: got %h, required beef", mem_read_data);
    end
    set_read(16'h0007);
    checks++;
    if (mem_read_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL mem_read_odd_alias: got %h, required beef", mem_read_data);
    end
    set_read(16'h0004);
    checks++;
    if (mem_read_data !== 16'h0000) begin
      errors++;
      $display("FAIL mem_read_other_word: got %h, required 0000", mem_read_data);
    end
    set_read(16'h0006);
    mem_read = 1'b0; #1;
    checks++;
    if (mem_read_data !== 16'h0000) begin
      errors++;
      $display("FAIL mem_read_disabled: got %h, required 0000", mem_read_data);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_read(16'h0006);
    mem_write_data = 16'h1111; mem_write_en = 1'b1; #1;
    checks++;
    if (mem_read_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL raw_before_edge: got %h, required beef", mem_read_data);
    end
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
    checks++;
    if (mem_read_data !== 16'h1111) begin
      errors++;
      $display("FAIL raw_after_edge: got %h, required 1111", mem_read_data);
    end
  endtask

  task automatic test_wrap();
    do_write(16'h0010, 16'h5A5A);
    set_read(16'h0000);
    checks++;
    if (mem_read_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL addr_wrap_word0: got %h, required 5a5a", mem_read_data);
    end
    set_read(16'h0006);
    checks++;
    if (mem_read_data !== 16'h1111) begin
      errors++;
      $display("FAIL addr_wrap_no_clobber: got %h, required 1111", mem_read_data);
    end
  endtask

  task automatic test_reset_clear();
    do_write(16'h0002, 16'hAAAA);
    set_read(16'h0002);
    checks++;
    if (mem_read_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL pre_reset_write: got %h, required aaaa", mem_read_data);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0; #1;
    checks++;
    if (mem_read_data !== 16'h0000) begin
      errors++;
      $display("FAIL async_clear: got %h, required 0000", mem_read_data);
    end
    a = 16'h0004; mem_write_data = 16'h1234; mem_write_en = 1'b1;
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
    checks++;
    if (mem_read_data !== 16'h0000) begin
      errors++;
      $display("FAIL write_in_reset: got %h, required 0000", mem_read_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_write(16'h0004, 16'h4321);
    set_read(16'h0004);
    checks++;
    if (mem_read_data !== 16'h4321) begin
      errors++;
      $display("FAIL first_write_after_reset: got %h, required 4321", mem_read_data);
    end
    set_read(16'h0000);
    checks++;
    if (mem_read_data !== 16'h0000) begin
      errors++;
      $display("FAIL word0_cleared: got %h, required 0000", mem_read_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_decode_ops();
    test_memory();
    test_back_to_back();
    test_wrap();
    test_reset_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
